// File: rtl/led_pkg.sv
// Shared definitions for the LED-array blocks: scan FSM states and width constants.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    // Row address width of the default 8-row array; display counters are 16 bits wide.
    localparam int unsigned LED_ROW_W = 3;
    localparam int unsigned LED_CNT_W = 16;

    function automatic int unsigned led_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_scan_shifter.sv
// Parallel-load column serializer: MSB first, two clocks per bit (sclk low, then high).
module led_scan_shifter
    import led_pkg::*;
#(
    parameter int unsigned COLS = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            run,
    input  logic [COLS-1:0] data,
    output logic            sclk,
    output logic            sdat,
    output logic            done
);

    localparam int unsigned BW = led_width(COLS);

    logic [COLS-1:0] sreg;
    logic [BW-1:0]   bit_cnt;

    assign sdat = sreg[COLS-1];

    // sclk doubles as the bit phase; done marks the high phase of the last bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            sreg    <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            done    <= 1'b0;
        end else if (load) begin
            sreg    <= data;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            done    <= 1'b0;
        end else if (run) begin
            if (!sclk) begin
                sclk <= 1'b1;
                done <= (bit_cnt == BW'(COLS - 1));
            end else begin
                sclk    <= 1'b0;
                done    <= 1'b0;
                sreg    <= {sreg[COLS-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED matrix row-scan controller. Define LED_SCAN_DIM_EN to add the i_bright
// global brightness input that trims the output-enable duty within DISPLAY.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned DISP_CYC = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_RESET,
    input  logic                    i_ena,
`ifdef LED_SCAN_DIM_EN
    input  logic [3:0]              i_bright,
`endif
    output logic [$clog2(ROWS)-1:0] o_rd_row,
    input  logic [COLS-1:0]         i_row_data,
    output logic                    o_sclk,
    output logic                    o_sdat,
    output logic                    o_latch,
    output logic                    o_oe_n,
    output logic [$clog2(ROWS)-1:0] o_row,
    output logic                    o_frame
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = LED_CNT_W;

    scan_state_t   state;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] disp_cnt;
    logic [CW:0]   on_lim;
    logic [CW:0]   disp_next;
    logic          abort;
    logic          sh_done;

    assign abort     = (state != ST_IDLE) && !i_ena;
    assign o_rd_row  = row_cnt;
    assign disp_next = {1'b0, disp_cnt} + (CW + 1)'(1);

`ifdef LED_SCAN_DIM_EN
    logic [3:0] bright_q;

    always_comb begin
        on_lim = (CW + 1)'((int'(bright_q) + 1) * int'(DISP_CYC / 16));
    end
`else
    always_comb begin
        on_lim = (CW + 1)'(DISP_CYC);
    end
`endif

    led_scan_shifter #(
        .COLS(COLS)
    ) u_shifter (
        .clk  (i_clk),
        .clr  (i_RESET || abort),
        .load (state == ST_LOAD),
        .run  (state == ST_SHIFT),
        .data (i_row_data),
        .sclk (o_sclk),
        .sdat (o_sdat),
        .done (sh_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_RESET || abort) begin
            state    <= ST_IDLE;
            row_cnt  <= '0;
            disp_cnt <= '0;
            o_row    <= '0;
            o_latch  <= 1'b0;
            o_frame  <= 1'b0;
            o_oe_n   <= 1'b1;
`ifdef LED_SCAN_DIM_EN
            if (i_RESET) bright_q <= '0;
`endif
        end else begin
            o_latch <= 1'b0;
            o_frame <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ena) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
`ifdef LED_SCAN_DIM_EN
                    bright_q <= i_bright;
`endif
                end
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (sh_done) begin
                        state   <= ST_LATCH;
                        o_latch <= 1'b1;
                        o_row   <= row_cnt;
                        o_frame <= (row_cnt == '0);
                    end
                end
                ST_LATCH: begin
                    state    <= ST_DISPLAY;
                    disp_cnt <= '0;
                    o_oe_n   <= 1'b0;
                end
                ST_DISPLAY: begin
                    if (disp_cnt == CW'(DISP_CYC - 1)) begin
                        state    <= ST_FETCH;
                        disp_cnt <= '0;
                        o_oe_n   <= 1'b1;
                        row_cnt  <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + RW'(1);
                    end else begin
                        disp_cnt <= disp_next[CW-1:0];
                        o_oe_n   <= (disp_next >= on_lim);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
